robo_top: RTL and testbench

Autonomous pipe-inspection robot controller: a left-hand wall-following FSM that turns per-cycle sensor readings (front wall, left wall, black floor cell, debris ahead) into one motion command per decision cycle. It also contains the operator-button front end that debounces three push-buttons and provides continuous or single-step execution. It sits between the robot's sensor interface and its motor/arm drivers.

---
 rtl/robo_top.sv | 186 ++++++++++++++++++
 tb/tb_robo_top.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/robo_top.sv
// Left-hand wall-following controller for a pipe-inspection robot, with a
// debounced three-button operator front end and single-step execution.
module robo_top #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic head,
    input  logic left,
    input  logic under,
    input  logic barrier,
    input  logic key_reset,
    input  logic key_mode,
    input  logic key_step,
    output logic avancar,
    output logic girar,
    output logic recolher_entulho,
    output logic btn_reset,
    output logic btn_mode,
    output logic btn_step,
    output logic step_mode,
    output logic done
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        SEARCH,
        FOLLOW,
        CORNER,
        ROTATE,
        REMOVE,
        DONE
    } state_t;

    logic [2:0] keys;
    logic [2:0] sync_a;
    logic [2:0] sync_b;
    logic [2:0] pulse;

    assign keys = {key_step, key_mode, key_reset};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= keys;
            sync_b <= sync_a;
        end
    end

    // The counter runs only while the synchronized level disagrees with the
    // accepted level, so both press and release need a full stable run.
    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [CW-1:0] cnt;
        logic          pressed;
        logic          pls;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt     <= '0;
                pressed <= 1'b0;
                pls     <= 1'b0;
            end else begin
                pls <= 1'b0;
                if (sync_b[i] == pressed) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt     <= '0;
                    pressed <= sync_b[i];
                    pls     <= sync_b[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign pulse[i] = pls;
    end

    assign btn_reset = pulse[0];
    assign btn_mode  = pulse[1];
    assign btn_step  = pulse[2];

    state_t state;
    state_t state_nxt;
    logic   departed;
    logic   departed_nxt;
    logic   done_nxt;
    logic   av_nxt;
    logic   gi_nxt;
    logic   re_nxt;
    logic   enable;

    // Enable uses the step_mode in force before any same-cycle toggle.
    assign enable = !step_mode || btn_step;

    always_comb begin
        state_nxt    = state;
        departed_nxt = departed;
        done_nxt     = done;
        av_nxt       = 1'b0;
        gi_nxt       = 1'b0;
        re_nxt       = 1'b0;
        if (btn_reset) begin
            state_nxt    = SEARCH;
            departed_nxt = 1'b0;
            done_nxt     = 1'b0;
        end else if (enable && state != DONE) begin
            if (!under) begin
                departed_nxt = 1'b1;
            end
            if (under && departed) begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
            end else if (barrier) begin
                re_nxt    = 1'b1;
                state_nxt = REMOVE;
            end else begin
                case (state)
                    SEARCH, REMOVE: begin
                        if (head) begin
                            gi_nxt    = 1'b1;
                            state_nxt = ROTATE;
                        end else begin
                            av_nxt    = 1'b1;
                            state_nxt = left ? FOLLOW : SEARCH;
                        end
                    end
                    FOLLOW: begin
                        if (!left) begin
                            gi_nxt    = 1'b1;
                            state_nxt = CORNER;
                        end else if (head) begin
                            gi_nxt    = 1'b1;
                            state_nxt = ROTATE;
                        end else begin
                            av_nxt = 1'b1;
                        end
                    end
                    CORNER: begin
                        if (head) begin
                            gi_nxt    = 1'b1;
                            state_nxt = ROTATE;
                        end else begin
                            av_nxt    = 1'b1;
                            state_nxt = FOLLOW;
                        end
                    end
                    ROTATE: begin
                        if (head) begin
                            gi_nxt = 1'b1;
                        end else begin
                            av_nxt    = 1'b1;
                            state_nxt = left ? FOLLOW : SEARCH;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= SEARCH;
            departed         <= 1'b0;
            done             <= 1'b0;
            step_mode        <= 1'b0;
            avancar          <= 1'b0;
            girar            <= 1'b0;
            recolher_entulho <= 1'b0;
        end else begin
            state            <= state_nxt;
            departed         <= departed_nxt;
            done             <= done_nxt;
            step_mode        <= step_mode ^ btn_mode;
            avancar          <= av_nxt;
            girar            <= gi_nxt;
            recolher_entulho <= re_nxt;
        end
    end

endmodule

// File: tb/tb_robo_top.sv
// Directed bench for robo_top: wall-following rules, debris handling, done
// detection, button debounce, step mode and soft/async resets.
module tb_robo_top;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic head = 1'b0, left = 1'b0, under = 1'b0, barrier = 1'b0;
    logic key_reset = 1'b0, key_mode = 1'b0, key_step = 1'b0;
    logic avancar, girar, recolher_entulho;
    logic btn_reset, btn_mode, btn_step, step_mode, done;

    int nvec = 0;
    int nfail = 0;

    robo_top #(.DEBOUNCE_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .head(head), .left(left), .under(under), .barrier(barrier),
        .key_reset(key_reset), .key_mode(key_mode), .key_step(key_step),
        .avancar(avancar), .girar(girar), .recolher_entulho(recolher_entulho),
        .btn_reset(btn_reset), .btn_mode(btn_mode), .btn_step(btn_step),
        .step_mode(step_mode), .done(done)
    );

    always #5 clock = ~clock;

    // Drive sensors away from the edge, then sample 1 time unit after it.
    task automatic cyc(input logic h, input logic l, input logic u, input logic b);
        head = h; left = l; under = u; barrier = b;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        head = 1'b0; left = 1'b0; under = 1'b0; barrier = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #4;
        nvec++;
        if ({avancar, girar, recolher_entulho, btn_reset, btn_mode, btn_step, step_mode, done} !== 8'b0) begin
            nfail++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {avancar, girar, recolher_entulho, btn_reset, btn_mode, btn_step, step_mode, done});
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_start_done();
        cyc(0, 0, 1, 0);
        nvec++;
        if (avancar !== 1'b1 || done !== 1'b0) begin
            nfail++;
            $display("FAIL start_cell: avancar=%b done=%b expected 1 0", avancar, done);
        end
        cyc(0, 0, 0, 0);
        nvec++;
        if (avancar !== 1'b1) begin
            nfail++;
            $display("FAIL departing: avancar=%b expected 1", avancar);
        end
        cyc(0, 0, 1, 1);
        nvec++;
        if (done !== 1'b1 || {avancar, girar, recolher_entulho} !== 3'b000) begin
            nfail++;
            $display("FAIL tube_end: done=%b acts=%b expected 1 000", done, {avancar, girar, recolher_entulho});
        end
        cyc(0, 0, 0, 0);
        nvec++;
        if (done !== 1'b1 || {avancar, girar, recolher_entulho} !== 3'b000) begin
            nfail++;
            $display("FAIL done_hold: done=%b acts=%b expected 1 000", done, {avancar, girar, recolher_entulho});
        end
    endtask

    task automatic test_corridor();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0);
            nvec++;
            if (avancar !== 1'b1 || girar !== 1'b0) begin
                nfail++;
                $display("FAIL corridor_%0d: avancar=%b girar=%b expected 1 0", i, avancar, girar);
            end
        end
        cyc(0, 0, 0, 0);
        nvec++;
        if (girar !== 1'b1 || avancar !== 1'b0) begin
            nfail++;
            $display("FAIL outside_corner: girar=%b avancar=%b expected 1 0", girar, avancar);
        end
        cyc(0, 0, 0, 0);
        nvec++;
        if (avancar !== 1'b1 || girar !== 1'b0) begin
            nfail++;
            $display("FAIL corner_ignores_left: avancar=%b girar=%b expected 1 0", avancar, girar);
        end
        cyc(0, 0, 0, 0);
        nvec++;
        if (girar !== 1'b1) begin
            nfail++;
            $display("FAIL back_in_follow: girar=%b expected 1", girar);
        end
    endtask

    task automatic test_dead_end();
        do_reset();
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0);
            nvec++;
            if (girar !== 1'b1 || avancar !== 1'b0) begin
                nfail++;
                $display("FAIL dead_end_turn_%0d: girar=%b avancar=%b expected 1 0", i, girar, avancar);
            end
        end
        cyc(0, 0, 0, 0);
        nvec++;
        if (avancar !== 1'b1) begin
            nfail++;
            $display("FAIL rotate_exit: avancar=%b expected 1", avancar);
        end
        cyc(0, 0, 0, 0);
        nvec++;
        if (avancar !== 1'b1 || girar !== 1'b0) begin
            nfail++;
            $display("FAIL in_search: avancar=%b girar=%b expected 1 0", avancar, girar);
        end
    endtask

    task automatic test_debris();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 1);
            nvec++;
            if ({avancar, girar, recolher_entulho} !== 3'b001) begin
                nfail++;
                $display("FAIL debris_%0d: acts=%b expected 001", i, {avancar, girar, recolher_entulho});
            end
        end
        cyc(0, 0, 0, 0);
        nvec++;
        if ({avancar, girar, recolher_entulho} !== 3'b100) begin
            nfail++;
            $display("FAIL debris_clear: acts=%b expected 100", {avancar, girar, recolher_entulho});
        end
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        nvec++;
        if ({avancar, girar, recolher_entulho} !== 3'b010) begin
            nfail++;
            $display("FAIL remove_head: acts=%b expected 010", {avancar, girar, recolher_entulho});
        end
        // Asynchronous abort in the middle of a removal cycle.
        cyc(0, 0, 0, 1);
        #1 reset = 1'b0;
        #1;
        nvec++;
        if ({avancar, girar, recolher_entulho} !== 3'b000) begin
            nfail++;
            $display("FAIL async_abort: acts=%b expected 000", {avancar, girar, recolher_entulho});
        end
        @(negedge clock);
        barrier = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_soft_reset();
        bit seen;
        do_reset();
        cyc(0, 0, 0, 1);
        key_reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(0, 0, 0, 1);
            seen = btn_reset;
        end
        nvec++;
        if (!seen) begin
            nfail++;
            $display("FAIL btn_reset_pulse: got none expected 1 pulse within 20 cycles");
        end
        key_reset = 1'b0;
        cyc(0, 0, 1, 0);
        nvec++;
        if ({avancar, girar, recolher_entulho} !== 3'b000 || step_mode !== 1'b0) begin
            nfail++;
            $display("FAIL soft_reset: acts=%b step_mode=%b expected 000 0",
                     {avancar, girar, recolher_entulho}, step_mode);
        end
        cyc(0, 0, 1, 0);
        nvec++;
        if (avancar !== 1'b1 || done !== 1'b0) begin
            nfail++;
            $display("FAIL departed_cleared: avancar=%b done=%b expected 1 0", avancar, done);
        end
    endtask

    task automatic test_buttons();
        int pulses;
        int acts;
        int steps;
        bit seen;
        do_reset();
        key_mode = 1'b1;
        cyc(0, 0, 0, 0);
        key_mode = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 0);
            pulses += int'(btn_mode);
        end
        nvec++;
        if (pulses != 0 || step_mode !== 1'b0) begin
            nfail++;
            $display("FAIL glitch: pulses=%0d step_mode=%b expected 0 0", pulses, step_mode);
        end
        key_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            pulses += int'(btn_mode);
        end
        key_mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            pulses += int'(btn_mode);
        end
        nvec++;
        if (pulses != 1 || step_mode !== 1'b1) begin
            nfail++;
            $display("FAIL mode_press: pulses=%0d step_mode=%b expected 1 1", pulses, step_mode);
        end
        acts = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0);
            acts += int'(avancar) + int'(girar) + int'(recolher_entulho);
        end
        nvec++;
        if (acts != 0) begin
            nfail++;
            $display("FAIL step_idle: actions=%0d expected 0", acts);
        end
        steps = 0;
        key_step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            steps += int'(btn_step);
            acts += int'(avancar);
        end
        key_step = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            steps += int'(btn_step);
            acts += int'(avancar);
        end
        nvec++;
        if (steps != 1 || acts != 1) begin
            nfail++;
            $display("FAIL single_step: btn_step=%0d avancar=%0d expected 1 1", steps, acts);
        end
        key_reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(0, 0, 0, 1);
            seen = btn_reset;
        end
        key_reset = 1'b0;
        cyc(0, 0, 0, 1);
        nvec++;
        if (!seen || step_mode !== 1'b1 || {avancar, girar, recolher_entulho} !== 3'b000) begin
            nfail++;
            $display("FAIL soft_reset_step: seen=%b step_mode=%b acts=%b expected 1 1 000",
                     seen, step_mode, {avancar, girar, recolher_entulho});
        end
    endtask

    initial begin
        test_reset();
        test_start_done();
        test_corridor();
        test_dead_end();
        test_debris();
        test_soft_reset();
        test_buttons();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
